// File: rtl/afu_mem_pkg.sv
// Shared types for the afu_core memory-side responder: line/address widths,
// write-queue entry layout and RAM arbiter grant encoding.
package afu_mem_pkg;

    localparam int unsigned LINE_W      = 512;
    localparam int unsigned ADDR_FULL_W = 58;

    typedef struct packed {
        logic                   fence;
        logic [ADDR_FULL_W-1:0] addr;
        logic [LINE_W-1:0]      data;
    } wq_entry_t;

    localparam int unsigned WQ_ENTRY_W = $bits(wq_entry_t);

    typedef enum logic [1:0] {
        G_NONE,
        G_HOST,
        G_WR,
        G_RD
    } grant_e;

endpackage

// File: rtl/afu_mem_responder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and an occupancy count.
// Push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok_c;
    logic         pop_ok_c;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_ok_c  = pop_i && !empty_o;
    assign push_ok_c = push_i && (!full_o || pop_ok_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/afu_mem_responder.sv
// Memory-side responder for afu_core: queues TX read/write/fence beats, arbitrates a
// single-port line RAM (host > writes > reads) and returns reads in order after LAT cycles.
module afu_mem_responder
    import afu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RQ_AW    = 4,
    parameter int unsigned WQ_AW    = 4,
    parameter int unsigned LAT      = 4,
    parameter int unsigned AF_SLACK = 4
) (
    input  logic                   CLK_400M,
    input  logic                   spl_reset,
    input  logic                   cor_tx_rd_valid,
    input  logic [ADDR_FULL_W-1:0] cor_tx_rd_addr,
    input  logic                   cor_tx_wr_valid,
    input  logic                   cor_tx_fence_valid,
    input  logic [ADDR_FULL_W-1:0] cor_tx_wr_addr,
    input  logic [LINE_W-1:0]      cor_tx_data,
    output logic                   spl_tx_rd_almostfull,
    output logic                   spl_tx_wr_almostfull,
    output logic                   io_rx_rd_valid,
    output logic [LINE_W-1:0]      io_rx_data,
    output logic                   fence_done,
    output logic                   ovf_err,
    input  logic                   host_en,
    input  logic                   host_we,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [LINE_W-1:0]      host_wdata,
    output logic [LINE_W-1:0]      host_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned RQ_TH = (2 ** RQ_AW) - AF_SLACK;
    localparam int unsigned WQ_TH = (2 ** WQ_AW) - AF_SLACK;

    logic              rq_push_c, rq_pop_c, rq_acc_c, rq_empty_c, rq_full_c;
    logic [RQ_AW:0]    rq_count_c, rq_cnt_nxt_c;
    logic [ADDR_W-1:0] rq_head_c;
    logic              wq_push_c, wq_pop_c, wq_acc_c, wq_empty_c, wq_full_c;
    logic [WQ_AW:0]    wq_count_c, wq_cnt_nxt_c;
    wq_entry_t         wq_in_c, wq_head_c;
    grant_e            grant_c;

    logic [LINE_W-1:0] ram_q [DEPTH];
    logic [ADDR_W-1:0] ram_addr_c;
    logic              ram_we_c;
    logic [LINE_W-1:0] ram_wdata_c, ram_rdata_c;

    logic [LAT-1:0]    pv_q;
    logic [LINE_W-1:0] pd_q [LAT];
    logic [LINE_W-1:0] host_rdata_q;
    logic              fence_done_q, ovf_q, rd_af_q, wr_af_q;
    logic              unused_addr_bits_c;

    // A fence beat overrides a write strobe in the same cycle.
    assign rq_push_c = cor_tx_rd_valid;
    assign wq_push_c = cor_tx_wr_valid | cor_tx_fence_valid;
    assign wq_in_c   = {cor_tx_fence_valid, cor_tx_wr_addr, cor_tx_data};

    sync_fifo #(.W(ADDR_W), .AW(RQ_AW)) u_rq (
        .clk     (CLK_400M),
        .rst     (spl_reset),
        .push_i  (rq_push_c),
        .pop_i   (rq_pop_c),
        .wdata_i (cor_tx_rd_addr[ADDR_W-1:0]),
        .rdata_o (rq_head_c),
        .empty_o (rq_empty_c),
        .full_o  (rq_full_c),
        .count_o (rq_count_c)
    );

    sync_fifo #(.W(WQ_ENTRY_W), .AW(WQ_AW)) u_wq (
        .clk     (CLK_400M),
        .rst     (spl_reset),
        .push_i  (wq_push_c),
        .pop_i   (wq_pop_c),
        .wdata_i (wq_in_c),
        .rdata_o (wq_head_c),
        .empty_o (wq_empty_c),
        .full_o  (wq_full_c),
        .count_o (wq_count_c)
    );

    // Writes ahead of reads so a read observes every write queued no later than itself.
    always_comb begin
        grant_c = G_NONE;
        if (host_en)          grant_c = G_HOST;
        else if (!wq_empty_c) grant_c = G_WR;
        else if (!rq_empty_c) grant_c = G_RD;
    end

    assign rq_pop_c     = (grant_c == G_RD);
    assign wq_pop_c     = (grant_c == G_WR);
    assign rq_acc_c     = rq_push_c && (!rq_full_c || rq_pop_c);
    assign wq_acc_c     = wq_push_c && (!wq_full_c || wq_pop_c);
    assign rq_cnt_nxt_c = rq_count_c + (RQ_AW+1)'(rq_acc_c) - (RQ_AW+1)'(rq_pop_c);
    assign wq_cnt_nxt_c = wq_count_c + (WQ_AW+1)'(wq_acc_c) - (WQ_AW+1)'(wq_pop_c);

    always_comb begin
        ram_addr_c  = rq_head_c;
        ram_we_c    = 1'b0;
        ram_wdata_c = wq_head_c.data;
        case (grant_c)
            G_HOST: begin
                ram_addr_c  = host_addr;
                ram_we_c    = host_we;
                ram_wdata_c = host_wdata;
            end
            G_WR: begin
                ram_addr_c = wq_head_c.addr[ADDR_W-1:0];
                ram_we_c   = !wq_head_c.fence;
            end
            default: ;
        endcase
    end

    assign ram_rdata_c = ram_q[ram_addr_c];

    // Line RAM survives reset so preloaded contents remain visible.
    always_ff @(posedge CLK_400M) begin
        if (ram_we_c) ram_q[ram_addr_c] <= ram_wdata_c;
    end

    always_ff @(posedge CLK_400M or posedge spl_reset) begin
        if (spl_reset) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) pd_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
            pv_q[0] <= rq_pop_c;
            pd_q[0] <= rq_pop_c ? ram_rdata_c : '0;
        end
    end

    always_ff @(posedge CLK_400M or posedge spl_reset) begin
        if (spl_reset) begin
            host_rdata_q <= '0;
            fence_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            rd_af_q      <= 1'b0;
            wr_af_q      <= 1'b0;
        end else begin
            if ((grant_c == G_HOST) && !host_we) host_rdata_q <= ram_rdata_c;
            fence_done_q <= wq_pop_c && wq_head_c.fence;
            ovf_q        <= ovf_q | (rq_push_c && !rq_acc_c) | (wq_push_c && !wq_acc_c);
            rd_af_q      <= (rq_cnt_nxt_c >= (RQ_AW+1)'(RQ_TH));
            wr_af_q      <= (wq_cnt_nxt_c >= (WQ_AW+1)'(WQ_TH));
        end
    end

    // Address bits above the RAM index alias onto the same lines.
    assign unused_addr_bits_c = ^{cor_tx_rd_addr[ADDR_FULL_W-1:ADDR_W],
                                  wq_head_c.addr[ADDR_FULL_W-1:ADDR_W]};

    assign io_rx_rd_valid       = pv_q[LAT-1];
    assign io_rx_data           = pd_q[LAT-1];
    assign host_rdata           = host_rdata_q;
    assign fence_done           = fence_done_q;
    assign ovf_err              = ovf_q;
    assign spl_tx_rd_almostfull = rd_af_q;
    assign spl_tx_wr_almostfull = wr_af_q;

endmodule
